uart_rx_bit_sampler: RTL and testbench

//  Oversampled bit-recovery stage of UART RX; sits directly upstream of the RX deserializer.

---
 rtl/uart_rx_pkg.sv | 19 +
 rtl/uart_rx_edge_bit_counter.sv | 65 ++++++
 rtl/uart_rx_bit_sampler.sv | 74 +++++++
 tb/tb_uart_rx_bit_sampler.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared constants and helpers for the UART receive path (bit sampler and RX FSM).
package uart_rx_pkg;

  localparam int PRESCALE_W = 6;
  localparam int BIT_CNT_W  = 4;

  localparam logic [PRESCALE_W-1:0] PRESCALE_8  = PRESCALE_W'(8);
  localparam logic [PRESCALE_W-1:0] PRESCALE_16 = PRESCALE_W'(16);
  localparam logic [PRESCALE_W-1:0] PRESCALE_32 = PRESCALE_W'(32);

  function automatic logic is_legal_prescale(input logic [PRESCALE_W-1:0] p);
    return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Prescale latch plus oversampling-edge and bit-period counters for the UART RX sampler.
module uart_rx_edge_bit_counter
  import uart_rx_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic [PRESCALE_W-1:0] p_cur,
  output logic                  p_legal
);

  localparam logic [BIT_CNT_W-1:0] BIT_CNT_MAX = '1;

  logic                  enable_d_reg;
  logic [PRESCALE_W-1:0] p_reg;
  logic [PRESCALE_W-1:0] edge_cnt_reg;
  logic [PRESCALE_W-1:0] edge_cnt_next;
  logic [BIT_CNT_W-1:0]  bit_cnt_reg;
  logic [BIT_CNT_W-1:0]  bit_cnt_next;
  logic                  rise;

  always_comb begin
    rise    = enable & ~enable_d_reg;
    // The rising cycle already counts with the value that is being latched.
    p_cur   = rise ? prescale : p_reg;
    p_legal = is_legal_prescale(p_cur);
  end

  always_comb begin
    edge_cnt_next = '0;
    bit_cnt_next  = '0;
    if (enable && p_legal) begin
      if (edge_cnt_reg == p_cur - PRESCALE_W'(1)) begin
        bit_cnt_next = (bit_cnt_reg == BIT_CNT_MAX) ? bit_cnt_reg
                                                    : bit_cnt_reg + BIT_CNT_W'(1);
      end else begin
        edge_cnt_next = edge_cnt_reg + PRESCALE_W'(1);
        bit_cnt_next  = bit_cnt_reg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enable_d_reg <= 1'b0;
      p_reg        <= PRESCALE_8;
      edge_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
    end else begin
      enable_d_reg <= enable;
      if (rise) begin
        p_reg <= prescale;
      end
      edge_cnt_reg <= edge_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
    end
  end

  assign edge_cnt = edge_cnt_reg;
  assign bit_cnt  = bit_cnt_reg;

endmodule

// File: rtl/uart_rx_bit_sampler.sv
// UART RX bit recovery: counts oversampling edges and majority-votes three mid-bit samples.
module uart_rx_bit_sampler
  import uart_rx_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  sampled_bit,
  output logic                  sample_valid
);

  logic [PRESCALE_W-1:0] p_cur;
  logic                  p_legal;
  logic [PRESCALE_W-1:0] half_p;
  logic [2:0]            at_pt;
  logic                  active;
  logic                  s0_reg;
  logic                  s1_reg;
  logic                  sampled_bit_reg;
  logic                  strobe_reg;

  uart_rx_edge_bit_counter u_counter (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .prescale (prescale),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt),
    .p_cur    (p_cur),
    .p_legal  (p_legal)
  );

  assign half_p = p_cur >> 1;
  assign active = enable & p_legal;

  // at_pt[0..2] mark edges M-2, M-1, M; legal P keeps these clear of the wrap.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_pt
      assign at_pt[gi] = (edge_cnt == half_p - PRESCALE_W'(2) + PRESCALE_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_reg          <= 1'b0;
      s1_reg          <= 1'b0;
      sampled_bit_reg <= 1'b1;
      strobe_reg      <= 1'b0;
    end else begin
      strobe_reg <= 1'b0;
      if (active) begin
        if (at_pt[0]) begin
          s0_reg <= rx_in;
        end
        if (at_pt[1]) begin
          s1_reg <= rx_in;
        end
        if (at_pt[2]) begin
          sampled_bit_reg <= majority3(s0_reg, s1_reg, rx_in);
          strobe_reg      <= 1'b1;
        end
      end
    end
  end

  // A strobe falling in a cycle where enable drops (or reset hits) is suppressed.
  assign sample_valid = strobe_reg & enable & ~rst;
  assign sampled_bit  = sampled_bit_reg;

endmodule

// File: tb/tb_uart_rx_bit_sampler.sv
// Self-checking bench for uart_rx_bit_sampler: behavioural model plus directed literal checks.
module tb_uart_rx_bit_sampler;
  import uart_rx_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  enable = 1'b0;
  logic                  rx_in = 1'b1;
  logic [PRESCALE_W-1:0] prescale = 6'd8;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic                  sampled_bit;
  logic                  sample_valid;

  int checks = 0;
  int failures = 0;
  bit model_on = 1'b0;

  typedef struct {
    logic       v;
    logic [3:0] b;
    logic [5:0] e;
  } strobe_t;
  strobe_t strobes[$];

  // model state: m_cnt = consecutive enabled, counted cycles before the current one
  int   m_cnt = 0;
  int   m_p = 8;
  bit   m_legal = 1'b1;
  bit   m_en_prev = 1'b0;
  logic m_sb = 1'b1;
  bit   hist[$];

  uart_rx_bit_sampler dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .rx_in        (rx_in),
    .prescale     (prescale),
    .edge_cnt     (edge_cnt),
    .bit_cnt      (bit_cnt),
    .sampled_bit  (sampled_bit),
    .sample_valid (sample_valid)
  );

  always #5 clk = ~clk;

  function automatic bit legal_p(input int p);
    return (p == 8) || (p == 16) || (p == 32);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process and model advance, both at the falling edge.
  always @(negedge clk) begin
    int   exp_edge;
    int   exp_bit;
    bit   exp_valid;
    if (sample_valid === 1'b1) begin
      strobes.push_back('{v: sampled_bit, b: bit_cnt, e: edge_cnt});
    end
    if (model_on) begin
      exp_edge  = 0;
      exp_bit   = 0;
      exp_valid = 1'b0;
      if (m_legal && m_cnt > 0) begin
        exp_edge  = m_cnt % m_p;
        exp_bit   = (m_cnt / m_p > 15) ? 15 : m_cnt / m_p;
        exp_valid = enable && !rst && (exp_edge == m_p / 2 + 1);
      end
      chk("model_edge_cnt", 32'(edge_cnt), 32'(exp_edge));
      chk("model_bit_cnt", 32'(bit_cnt), 32'(exp_bit));
      chk("model_sample_valid", 32'(sample_valid), 32'(exp_valid));
      chk("model_sampled_bit", 32'(sampled_bit), 32'(m_sb));

      if (rst) begin
        m_cnt = 0; m_p = 8; m_legal = 1'b1; m_en_prev = 1'b0; m_sb = 1'b1;
        hist.delete();
      end else if (!enable) begin
        m_cnt = 0; m_en_prev = 1'b0;
        hist.delete();
      end else begin
        if (!m_en_prev) begin
          m_p = int'(prescale);
          m_legal = legal_p(m_p);
          m_cnt = 0;
          hist.delete();
        end
        m_en_prev = 1'b1;
        if (m_legal) begin
          if (m_cnt % m_p == m_p / 2) begin
            m_sb = (int'(hist[m_cnt-2]) + int'(hist[m_cnt-1]) + int'(rx_in)) >= 2;
          end
          hist.push_back(rx_in);
          m_cnt++;
        end
      end
    end
  end

  task automatic step(input logic en, input logic rx, input logic [5:0] ps, input logic r);
    enable = en; rx_in = rx; prescale = ps; rst = r;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 6'd8, 1'b0);
  endtask

  initial begin
    step(1'b0, 1'b1, 6'd8, 1'b1);
    step(1'b0, 1'b1, 6'd8, 1'b1);
    model_on = 1'b1;
    chk("reset_edge_cnt", 32'(edge_cnt), 0);
    chk("reset_bit_cnt", 32'(bit_cnt), 0);
    chk("reset_sampled_bit", 32'(sampled_bit), 1);
    chk("reset_sample_valid", 32'(sample_valid), 0);
    idle(2);

    // P=8, rx=0: strobes at edge 5 of bits 0,1,2
    strobes.delete();
    for (int i = 0; i < 26; i++) step(1'b1, 1'b0, 6'd8, 1'b0);
    idle(2);
    chk("p8_strobe_count", 32'(strobes.size()), 3);
    for (int i = 0; i < strobes.size(); i++) begin
      chk("p8_strobe_edge", 32'(strobes[i].e), 5);
      chk("p8_strobe_bit", 32'(strobes[i].b), 32'(i));
      chk("p8_strobe_val", 32'(strobes[i].v), 0);
    end

    // P=16 glitch: single-edge glitch loses the vote, two-edge glitch wins
    strobes.delete();
    for (int i = 0; i < 32; i++)
      step(1'b1, !((i == 7) || (i == 22) || (i == 23)), 6'd16, 1'b0);
    idle(2);
    chk("glitch_strobe_count", 32'(strobes.size()), 2);
    if (strobes.size() == 2) begin
      chk("glitch_single_val", 32'(strobes[0].v), 1);
      chk("glitch_double_val", 32'(strobes[1].v), 0);
    end

    // P=16 frame: start, 0x55 LSB-first, stop
    strobes.delete();
    for (int i = 0; i < 160; i++) step(1'b1, logic'((i / 16) % 2), 6'd16, 1'b0);
    idle(2);
    chk("frame_strobe_count", 32'(strobes.size()), 10);
    for (int j = 0; j < strobes.size(); j++) begin
      chk("frame_bit_val", 32'(strobes[j].v), 32'(j % 2));
      chk("frame_bit_cnt", 32'(strobes[j].b), 32'(j));
    end

    // P=32, enable dropped at edge 10 of bit 3
    strobes.delete();
    for (int i = 0; i < 106; i++) step(1'b1, ((i / 32) == 0) || ((i / 32) == 2), 6'd32, 1'b0);
    chk("drop_pre_edge", 32'(edge_cnt), 10);
    chk("drop_pre_bit", 32'(bit_cnt), 3);
    step(1'b0, 1'b0, 6'd32, 1'b0);
    chk("drop_edge_cleared", 32'(edge_cnt), 0);
    chk("drop_bit_cleared", 32'(bit_cnt), 0);
    chk("drop_sampled_hold", 32'(sampled_bit), 1);
    chk("drop_strobe_count", 32'(strobes.size()), 3);
    idle(2);

    // P=16, reset mid-frame at bit 2 edge 8
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 6'd16, 1'b0);
    chk("rst_pre_edge", 32'(edge_cnt), 8);
    chk("rst_pre_bit", 32'(bit_cnt), 2);
    chk("rst_pre_sampled", 32'(sampled_bit), 0);
    step(1'b1, 1'b0, 6'd16, 1'b1);
    chk("rst_edge", 32'(edge_cnt), 0);
    chk("rst_bit", 32'(bit_cnt), 0);
    chk("rst_sampled", 32'(sampled_bit), 1);
    chk("rst_valid", 32'(sample_valid), 0);
    idle(2);

    // illegal prescale 12 latched; mid-enable change to 16 ignored
    strobes.delete();
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, (i < 5) ? 6'd12 : 6'd16, 1'b0);
    chk("illegal_edge", 32'(edge_cnt), 0);
    chk("illegal_bit", 32'(bit_cnt), 0);
    chk("illegal_no_strobe", 32'(strobes.size()), 0);
    step(1'b0, 1'b0, 6'd16, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 6'd16, 1'b0);
    chk("relatch_edge", 32'(edge_cnt), 4);
    chk("relatch_bit", 32'(bit_cnt), 1);
    chk("relatch_strobes", 32'(strobes.size()), 1);
    idle(2);

    // bit_cnt saturation
    for (int i = 0; i < 140; i++) step(1'b1, 1'b1, 6'd8, 1'b0);
    chk("sat_bit", 32'(bit_cnt), 15);
    chk("sat_edge", 32'(edge_cnt), 4);
    idle(2);

    // randomized traffic, checked every cycle by the model
    begin
      logic       en_r = 1'b0;
      logic       line = 1'b1;
      logic [5:0] ps_r = 6'd16;
      logic [5:0] ps_tab[9] = '{6'd8, 6'd16, 6'd32, 6'd8, 6'd16, 6'd32, 6'd12, 6'd0, 6'd33};
      for (int c = 0; c < 4000; c++) begin
        logic rb;
        if (en_r) begin
          if ($urandom_range(0, 299) == 0) en_r = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          en_r = 1'b1;
        end
        if ($urandom_range(0, 49) == 0) ps_r = ps_tab[$urandom_range(0, 8)];
        if ($urandom_range(0, 19) == 0) line = ~line;
        rb = ($urandom_range(0, 14) == 0) ? ~line : line;
        step(en_r, rb, ps_r, $urandom_range(0, 999) < 3);
      end
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
